// File: rtl/obstacle_field.sv
// Obstacle field: a small pool of scrolling sprite channels with randomised
// spawn spacing, a registered pixel output and an optional sticky collision
// flag against the player's pixel.
// Optional feature: define OBSTACLE_COLLISION_EN to build the collision flag;
// otherwise hit is tied low and dino_px is ignored.
module obstacle_field #(
    parameter int N_OBS    = 3,
    parameter int SPR_W    = 60,
    parameter int SPR_H    = 58,
    parameter int TOP_ROW  = 344,
    parameter int SCREEN_W = 640,
    parameter int MIN_GAP  = 200,
    // Cactus: trunk in cols 24..35, arms in cols 8..13 / 46..51 on rows 10..33,
    // a crossbar on rows 34..37, plain trunk below. Row 0 is the least
    // significant SPR_W-bit slice.
    parameter logic [SPR_W*SPR_H-1:0] SPRITE = {
        {20{60'h000000FFF000000}},
        {4{60'h00FFFFFFFFFFF00}},
        {24{60'h00FC00FFF003F00}},
        {10{60'h000000FFF000000}}
    }
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [8:0]       row_addr,
    input  logic [9:0]       col_addr,
    input  logic             game_status,
    input  logic             fresh,
    input  logic [3:0]       speed,
    input  logic             dino_px,
    output logic             px,
    output logic [N_OBS-1:0] obs_active,
    output logic             hit
);
    localparam int IDX_W = $clog2(SPR_W * SPR_H);
    localparam logic [8:0]         ROW_LO  = 9'(TOP_ROW);
    localparam logic [8:0]         ROW_HI  = 9'(TOP_ROW + SPR_H);
    localparam logic signed [10:0] SCR_X   = 11'(SCREEN_W);
    localparam logic signed [10:0] W_X     = 11'(SPR_W);
    localparam logic signed [11:0] SCR_S   = 12'(SCREEN_W);
    localparam logic signed [11:0] W_S     = 12'(SPR_W);
    localparam logic [10:0]        GAP_MIN = 11'(MIN_GAP);

    logic                    fresh_d;
    logic                    tick;
    logic                    run;
    logic signed [10:0]      pos_x [N_OBS];
    logic [N_OBS-1:0]        act;
    logic [9:0]              gap;
    logic [15:0]             lfsr;

    logic signed [10:0]      nx_x [N_OBS];
    logic [N_OBS-1:0]        nx_act;
    logic [9:0]              nx_gap;
    logic [15:0]             nx_lfsr;
    logic                    spawn_req;
    logic                    placed;
    logic signed [10:0]      moved;
    logic [10:0]             gap_sum;
    logic                    pix;

    assign tick       = fresh_d & ~fresh;
    assign run        = tick & game_status;
    assign obs_active = act;

    // Per-tick motion, retirement, spawn placement and gap/LFSR bookkeeping.
    always_comb begin
        nx_x      = pos_x;
        nx_act    = act;
        nx_gap    = gap;
        nx_lfsr   = lfsr;
        placed    = 1'b0;
        moved     = '0;
        gap_sum   = {1'b0, gap} + {7'b0, speed};
        // Threshold is judged on the gap as it stood before this tick's add.
        spawn_req = {1'b0, gap} >= (GAP_MIN + {4'b0, lfsr[6:0]});
        if (run) begin
            for (int i = 0; i < N_OBS; i++) begin
                if (act[i]) begin
                    moved = pos_x[i] - $signed({7'b0, speed});
                    if (moved + W_X <= 11'sd0) begin
                        nx_act[i] = 1'b0;
                        nx_x[i]   = SCR_X;
                    end else begin
                        nx_x[i]   = moved;
                    end
                end
            end
            // Searching the post-move flags lets a slot retired this tick be reused.
            if (spawn_req) begin
                for (int i = 0; i < N_OBS; i++) begin
                    if (!placed && !nx_act[i]) begin
                        nx_act[i] = 1'b1;
                        nx_x[i]   = SCR_X;
                        placed    = 1'b1;
                    end
                end
            end
            if (placed) begin
                nx_gap  = '0;
                nx_lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            end else begin
                nx_gap  = gap_sum[10] ? 10'h3FF : gap_sum[9:0];
            end
        end
    end

    // Channel, gap, LFSR and frame-strobe state.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            fresh_d <= 1'b0;
            act     <= '0;
            gap     <= '0;
            lfsr    <= 16'hACE1;
            for (int i = 0; i < N_OBS; i++) pos_x[i] <= SCR_X;
        end else begin
            fresh_d <= fresh;
            act     <= nx_act;
            gap     <= nx_gap;
            lfsr    <= nx_lfsr;
            pos_x   <= nx_x;
        end
    end

    logic signed [11:0]  col_s;
    logic signed [11:0]  x_s;
    logic signed [11:0]  off;
    logic [8:0]          row_off;
    logic [IDX_W-1:0]    idx;
    logic                in_band;

    // OR of every active channel's sprite bit at the scan address, clipped at both screen edges.
    always_comb begin
        pix     = 1'b0;
        x_s     = '0;
        off     = '0;
        idx     = '0;
        col_s   = $signed({2'b0, col_addr});
        row_off = row_addr - ROW_LO;
        in_band = (row_addr >= ROW_LO) && (row_addr < ROW_HI);
        for (int i = 0; i < N_OBS; i++) begin
            x_s = {pos_x[i][10], pos_x[i]};
            off = col_s - x_s;
            if (act[i] && in_band && (col_s >= x_s) && (col_s < x_s + W_S) && (col_s < SCR_S)) begin
                idx = IDX_W'(int'(row_off) * SPR_W + int'(off));
                pix = pix | SPRITE[idx];
            end
        end
    end

    // Registered pixel output.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) px <= 1'b0;
        else       px <= pix;
    end

`ifdef OBSTACLE_COLLISION_EN
    // Sticky collision: once set, only RESET clears it.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET)             hit <= 1'b0;
        else if (pix & dino_px) hit <= 1'b1;
    end
`else
    logic unused_dino;
    assign unused_dino = dino_px;
    assign hit         = 1'b0;
`endif

endmodule

// File: tb/tb_obstacle_field.sv
// Bench for obstacle_field: directed literal checks pinning the first spawn,
// sprite addressing, freeze, collision, left-edge retirement and mid-frame
// reset, then a long randomised run compared every cycle against a
// behavioural model of the obstacle field.
module tb_obstacle_field;
    localparam int N    = 3;
    localparam int W    = 60;
    localparam int H    = 58;
    localparam int TOP  = 344;
    localparam int SCR  = 640;
    localparam int MING = 200;

    function automatic logic [W*H-1:0] make_spr();
        logic [W*H-1:0] s;
        for (int i = 0; i < W*H; i++) s[i] = (((i*7 + (i/W)*3) % 5) < 2);
        return s;
    endfunction
    localparam logic [W*H-1:0] SPR = make_spr();

`ifdef OBSTACLE_COLLISION_EN
    localparam int HIT_EXP = 1;
`else
    localparam int HIT_EXP = 0;
`endif

    logic         clk = 1'b0;
    logic         RESET = 1'b0;
    logic [8:0]   row_addr = '0;
    logic [9:0]   col_addr = '0;
    logic         game_status = 1'b0;
    logic         fresh = 1'b0;
    logic [3:0]   speed = '0;
    logic         dino_px = 1'b0;
    logic         px;
    logic [N-1:0] obs_active;
    logic         hit;

    always #5 clk = ~clk;

    obstacle_field #(
        .N_OBS(N), .SPR_W(W), .SPR_H(H), .TOP_ROW(TOP),
        .SCREEN_W(SCR), .MIN_GAP(MING), .SPRITE(SPR)
    ) dut (
        .clk(clk), .RESET(RESET), .row_addr(row_addr), .col_addr(col_addr),
        .game_status(game_status), .fresh(fresh), .speed(speed),
        .dino_px(dino_px), .px(px), .obs_active(obs_active), .hit(hit)
    );

    // Behavioural model state.
    int           m_x [N];
    bit           m_act [N];
    int           m_gap;
    int           m_lfsr;
    bit           m_fd;
    bit           m_hit;
    logic [W*H-1:0] spr_v = SPR;

    bit           exp_px;
    bit [N-1:0]   exp_act;
    bit           exp_hit;
    bit           chk_en = 1'b0;
    int           errors = 0;
    int           checks = 0;

    function automatic bit model_pix(input int r, input int c);
        bit p = 1'b0;
        for (int i = 0; i < N; i++)
            if (m_act[i] && r >= TOP && r < TOP + H && c >= m_x[i] && c < m_x[i] + W && c < SCR)
                p = p | spr_v[(r - TOP) * W + (c - m_x[i])];
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_x[i] = SCR; m_act[i] = 1'b0; end
        m_gap = 0; m_lfsr = 'hACE1; m_fd = 1'b0; m_hit = 1'b0;
    endtask

    task automatic model_tick(input int sp);
        bit req = (m_gap >= MING + (m_lfsr & 127));
        int slot = -1;
        for (int i = 0; i < N; i++)
            if (m_act[i]) begin
                m_x[i] = m_x[i] - sp;
                if (m_x[i] + W <= 0) m_act[i] = 1'b0;
            end
        if (req)
            for (int i = N - 1; i >= 0; i--) if (!m_act[i]) slot = i;
        if (slot >= 0) begin
            m_act[slot] = 1'b1;
            m_x[slot]   = SCR;
            m_gap       = 0;
            m_lfsr      = (m_lfsr >> 1) | ((((m_lfsr) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
        end else begin
            m_gap = (m_gap + sp > 1023) ? 1023 : m_gap + sp;
        end
    endtask

    // One clock: drive inputs, let the edge pass, advance the model, publish expectations.
    task automatic cycle(input bit rst, input bit f, input bit gs, input int sp,
                         input int r, input int c, input bit d);
        bit p, tk;
        if (rst) chk_en = 1'b0;
        RESET = rst; fresh = f; game_status = gs; speed = sp[3:0];
        row_addr = r[8:0]; col_addr = c[9:0]; dino_px = d;
        p  = model_pix(r, c);
        tk = m_fd & ~f;
        @(posedge clk); #1;
        if (rst) begin
            model_reset();
            exp_px = 1'b0;
        end else begin
            if (HIT_EXP != 0 && p && d) m_hit = 1'b1;
            if (tk && gs) model_tick(sp);
            m_fd   = f;
            exp_px = p;
        end
        exp_hit = m_hit;
        for (int i = 0; i < N; i++) exp_act[i] = m_act[i];
        chk_en = 1'b1;
    endtask

    task automatic do_tick(input bit gs, input int sp, input int r, input int c);
        cycle(1'b0, 1'b1, gs, sp, r, c, 1'b0);
        cycle(1'b0, 1'b0, gs, sp, r, c, 1'b0);
    endtask

    task automatic lit(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (px !== exp_px) begin
                errors++;
                $display("FAIL px @%0t: got %b expected %b", $time, px, exp_px);
            end
            checks++;
            if (obs_active !== exp_act) begin
                errors++;
                $display("FAIL obs_active @%0t: got %b expected %b", $time, obs_active, exp_act);
            end
            checks++;
            if (hit !== exp_hit) begin
                errors++;
                $display("FAIL hit @%0t: got %b expected %b", $time, hit, exp_hit);
            end
        end
    end

    initial begin
        int r, c, ch;
        model_reset();
        #1;
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        lit("reset_obs_active", int'(obs_active), 0);
        lit("reset_px", int'(px), 0);
        lit("reset_hit", int'(hit), 0);
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        // gap before running tick k is 10*(k-1); first qualifies (>=297) at tick 31.
        for (int k = 1; k <= 30; k++) do_tick(1'b1, 10, 0, 0);
        lit("no_spawn_tick30", int'(obs_active), 0);
        do_tick(1'b1, 10, 0, 0);
        lit("first_spawn_tick31", int'(obs_active), 1);

        // 54 more ticks bring channel 0 to x=100.
        for (int k = 0; k < 54; k++) do_tick(1'b1, 10, 0, 0);
        cycle(1'b0, 1'b0, 1'b1, 10, TOP, 130, 1'b0);
        lit("px_sprite30", int'(px), 1);
        cycle(1'b0, 1'b0, 1'b1, 10, TOP, 99, 1'b0);
        lit("px_left_of_x", int'(px), 0);

        // Frozen ticks: nothing moves, rendering continues.
        for (int k = 0; k < 10; k++) do_tick(1'b0, 10, TOP, 130);
        cycle(1'b0, 1'b0, 1'b0, 10, TOP, 130, 1'b0);
        lit("px_after_freeze", int'(px), 1);

        // Collision on a set sprite pixel, then sticky after dino_px drops.
        cycle(1'b0, 1'b0, 1'b1, 0, TOP, 130, 1'b1);
        lit("hit_set", int'(hit), HIT_EXP);
        cycle(1'b0, 1'b0, 1'b1, 0, TOP, 130, 1'b0);
        lit("hit_sticky", int'(hit), HIT_EXP);

        // Left edge: 15 ticks -> x=-50 still active, col 0 shows sprite bit 50.
        for (int k = 0; k < 15; k++) do_tick(1'b1, 10, 0, 0);
        lit("ch0_active_xm50", int'(obs_active[0]), 1);
        cycle(1'b0, 1'b0, 1'b1, 10, TOP, 0, 1'b0);
        lit("px_left_clip", int'(px), 1);
        cycle(1'b0, 1'b0, 1'b1, 10, TOP, 1023, 1'b0);
        lit("px_no_wrap", int'(px), 0);
        do_tick(1'b1, 10, 0, 0);
        lit("ch0_retired_xm60", int'(obs_active[0]), 0);

        // Mid-frame reset takes effect before any clock edge.
        chk_en = 1'b0;
        fresh  = 1'b1;
        #2;
        RESET  = 1'b1;
        #1;
        lit("async_reset_active", int'(obs_active), 0);
        lit("async_reset_px", int'(px), 0);
        lit("async_reset_hit", int'(hit), 0);
        cycle(1'b1, 1'b0, 1'b1, 10, 0, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 10, 0, 0, 1'b0);

        // Randomised run against the model.
        for (int n = 0; n < 20000; n++) begin
            ch = $urandom_range(0, N - 1);
            r  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(TOP - 4, TOP + H + 4);
            c  = m_x[ch] + $urandom_range(0, 70) - 5;
            if (c < 0) c = $urandom_range(0, 20);
            if (c > 1023 || $urandom_range(0, 7) == 0) c = $urandom_range(0, 1023);
            cycle($urandom_range(0, 2999) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 15), r, c,
                  $urandom_range(0, 3) == 0);
        end

        chk_en = 1'b0;
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
